// File: rtl/fetch_stage.sv
// Instruction fetch stage with IF/ID pipeline register for the MIPS core.
// Drives a req/ack instruction port, buffers one word across decode stalls, and drops stale fetches on redirect.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc4,
  output logic [15:0] if_imm16,
  output logic        if_sign_extend
);

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    HOLD    = 2'd1,
    DISCARD = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] old_addr;
  logic [31:0] hold_instr;
  logic [31:0] hold_pc4;

  logic [31:0] pc_plus4;
  logic [31:0] target;
  logic [5:0]  opcode;

  assign pc_plus4 = pc + 32'd4;
  assign target   = {redirect_pc[31:2], 2'b00};

  // HOLD is the only state without an outstanding request; DISCARD keeps presenting the abandoned address.
  assign imem_req  = !reset && (state != HOLD);
  assign imem_addr = (state == DISCARD) ? old_addr : pc;

  assign opcode         = if_instr[31:26];
  assign if_imm16       = if_instr[15:0];
  assign if_sign_extend = !((opcode == 6'h0C) || (opcode == 6'h0D) || (opcode == 6'h0E));

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= FETCH;
      pc         <= RESET_PC;
      old_addr   <= 32'h0;
      hold_instr <= 32'h0;
      hold_pc4   <= 32'h0;
      if_valid   <= 1'b0;
      if_instr   <= 32'h0;
      if_pc4     <= 32'h0;
    end else begin
      case (state)
        FETCH: begin
          if (redirect) begin
            pc       <= target;
            if_valid <= 1'b0;
            if_instr <= 32'h0;
            // An unacknowledged request cannot be withdrawn, so its address is kept until the ack arrives.
            if (!imem_ack) begin
              old_addr <= pc;
              state    <= DISCARD;
            end
          end else if (imem_ack) begin
            pc <= pc_plus4;
            if (stall) begin
              hold_instr <= imem_rdata;
              hold_pc4   <= pc_plus4;
              state      <= HOLD;
            end else begin
              if_valid <= 1'b1;
              if_instr <= imem_rdata;
              if_pc4   <= pc_plus4;
            end
          end else if (!stall) begin
            if_valid <= 1'b0;
            if_instr <= 32'h0;
          end
        end

        HOLD: begin
          if (redirect) begin
            pc       <= target;
            if_valid <= 1'b0;
            if_instr <= 32'h0;
            state    <= FETCH;
          end else if (!stall) begin
            if_valid <= 1'b1;
            if_instr <= hold_instr;
            if_pc4   <= hold_pc4;
            state    <= FETCH;
          end
        end

        DISCARD: begin
          if_valid <= 1'b0;
          if_instr <= 32'h0;
          if (redirect) begin
            pc <= target;
          end
          if (imem_ack) begin
            state <= FETCH;
          end
        end

        default: begin
          state <= FETCH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus randomized traffic against a transaction-level model.
module tb_fetch_stage;

  logic        clk;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc4;
  logic [15:0] if_imm16;
  logic        if_sign_extend;

  logic        w_req;
  logic [31:0] w_addr;
  logic        w_valid;
  logic [31:0] w_instr;
  logic [31:0] w_pc4;
  logic [15:0] w_imm16;
  logic        w_sext;

  int checks = 0;
  int errors = 0;

  fetch_stage dut (
    .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .stall(stall),
    .redirect(redirect), .redirect_pc(redirect_pc), .if_valid(if_valid),
    .if_instr(if_instr), .if_pc4(if_pc4), .if_imm16(if_imm16),
    .if_sign_extend(if_sign_extend)
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .reset(reset), .imem_req(w_req), .imem_addr(w_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .stall(stall),
    .redirect(redirect), .redirect_pc(redirect_pc), .if_valid(w_valid),
    .if_instr(w_instr), .if_pc4(w_pc4), .if_imm16(w_imm16),
    .if_sign_extend(w_sext)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: the next address to fetch, whether a discarded request is still outstanding,
  // whether a fetched word is parked waiting for decode, and what decode currently sees.
  logic [31:0] m_pc;
  bit          m_stale;
  logic [31:0] m_stale_addr;
  bit          m_held;
  logic [31:0] m_held_instr;
  logic [31:0] m_held_pc4;
  bit          m_valid;
  logic [31:0] m_instr;
  logic [31:0] m_pc4;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", tag, observed, expected, $time);
    end
  endtask

  function automatic logic [31:0] model_addr();
    return m_stale ? m_stale_addr : m_pc;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    w = $urandom;
    case ($urandom_range(0, 4))
      0: w[31:26] = 6'h0C;
      1: w[31:26] = 6'h0D;
      2: w[31:26] = 6'h0E;
      3: w[31:26] = 6'h08;
      default: ;
    endcase
    return w;
  endfunction

  task automatic model_clear();
    m_valid = 1'b0;
    m_instr = 32'h0;
  endtask

  task automatic model_step(input bit rst, input bit st, input bit rd, input logic [31:0] rpc,
                            input bit ak, input logic [31:0] rdat);
    logic [31:0] tgt;
    tgt = rpc & 32'hFFFF_FFFC;
    if (rst) begin
      m_pc = 32'h0; m_stale = 0; m_stale_addr = 32'h0; m_held = 0;
      m_held_instr = 32'h0; m_held_pc4 = 32'h0;
      m_valid = 0; m_instr = 32'h0; m_pc4 = 32'h0;
    end else if (m_stale) begin
      model_clear();
      if (rd) m_pc = tgt;
      if (ak) m_stale = 0;
    end else if (m_held) begin
      if (rd) begin
        m_pc = tgt; model_clear(); m_held = 0;
      end else if (!st) begin
        m_valid = 1; m_instr = m_held_instr; m_pc4 = m_held_pc4; m_held = 0;
      end
    end else if (rd) begin
      if (!ak) begin
        m_stale = 1; m_stale_addr = m_pc;
      end
      m_pc = tgt; model_clear();
    end else if (ak) begin
      if (st) begin
        m_held = 1; m_held_instr = rdat; m_held_pc4 = m_pc + 32'd4;
      end else begin
        m_valid = 1; m_instr = rdat; m_pc4 = m_pc + 32'd4;
      end
      m_pc = m_pc + 32'd4;
    end else if (!st) begin
      model_clear();
    end
  endtask

  task automatic compare_all();
    logic [5:0] op;
    bit exp_req;
    exp_req = !reset && !m_held;
    op = m_instr[31:26];
    checkOutput("imem_req", {31'h0, imem_req}, {31'h0, exp_req});
    checkOutput("imem_addr", imem_addr, model_addr());
    checkOutput("if_valid", {31'h0, if_valid}, {31'h0, m_valid});
    checkOutput("if_instr", if_instr, m_instr);
    if (m_valid) checkOutput("if_pc4", if_pc4, m_pc4);
    checkOutput("if_imm16", {16'h0, if_imm16}, {16'h0, m_instr[15:0]});
    checkOutput("if_sign_extend", {31'h0, if_sign_extend},
                {31'h0, !(op == 6'h0C || op == 6'h0D || op == 6'h0E)});
  endtask

  // One clock of stimulus, entered and left at a falling edge; ack is only offered while a request is up.
  task automatic applyStimulus(input bit rst, input bit st, input bit rd, input logic [31:0] rpc,
                               input bit ak, input bit addr_data, input logic [31:0] rdat);
    bit ak_eff;
    logic [31:0] d;
    ak_eff = ak && !rst && !m_held;
    d = addr_data ? model_addr() : rdat;
    reset = rst; stall = st; redirect = rd; redirect_pc = rpc;
    imem_ack = ak_eff; imem_rdata = d;
    model_step(rst, st, rd, rpc, ak_eff, d);
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    imem_ack = 1'b0; imem_rdata = 32'h0;

    // Reset state
    @(negedge clk);
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    checkOutput("reset_sext", {31'h0, if_sign_extend}, 32'h1);
    checkOutput("reset_imm16", {16'h0, if_imm16}, 32'h0);
    checkOutput("wrap_reset_req", {31'h0, w_req}, 32'h0);

    // Zero-wait memory returning the address as data; the wrapping instance shares the stimulus
    reset = 1'b0;
    #1;
    checkOutput("first_req", {31'h0, imem_req}, 32'h1);
    checkOutput("first_addr", imem_addr, 32'h0);
    checkOutput("wrap_first_addr", w_addr, 32'hFFFF_FFFC);
    applyStimulus(0, 0, 0, 0, 1, 1, 0);
    checkOutput("wrap_second_addr", w_addr, 32'h0);
    for (int i = 0; i < 7; i++) begin
      applyStimulus(0, 0, 0, 0, 1, 1, 0);
      checkOutput("stream_pc4", if_pc4, if_instr + 32'd4);
    end

    // Two-cycle memory latency leaves bubbles
    for (int i = 0; i < 6; i++) applyStimulus(0, 0, 0, 0, i % 2, 1, 0);
    checkOutput("latency_valid", {31'h0, if_valid}, 32'h1);

    // Stall during the ack of 0x8
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, 1, 0);
    applyStimulus(0, 0, 0, 0, 1, 1, 0);
    applyStimulus(0, 1, 0, 0, 1, 1, 0);
    checkOutput("hold_req", {31'h0, imem_req}, 32'h0);
    checkOutput("hold_keeps_4", if_instr, 32'h4);
    applyStimulus(0, 1, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    checkOutput("hold_release_8", if_instr, 32'h8);
    checkOutput("resume_addr", imem_addr, 32'hC);

    // Redirect to 0x100 while the 0x10 request is pending
    applyStimulus(0, 0, 0, 0, 1, 1, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 1, 32'h100, 0, 0, 0);
    checkOutput("discard_addr", imem_addr, 32'h10);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, 0, 32'hDEAD_BEEF);
    checkOutput("stale_dropped", {31'h0, if_valid}, 32'h0);
    checkOutput("target_addr", imem_addr, 32'h100);
    applyStimulus(0, 0, 0, 0, 1, 1, 0);
    checkOutput("target_pc4", if_pc4, 32'h104);

    // Immediate sign-extension control
    applyStimulus(0, 0, 0, 0, 1, 0, 32'h3421_8000);
    checkOutput("ori_imm16", {16'h0, if_imm16}, 32'h8000);
    checkOutput("ori_sext", {31'h0, if_sign_extend}, 32'h0);
    applyStimulus(0, 0, 0, 0, 1, 0, 32'h2021_8000);
    checkOutput("addi_sext", {31'h0, if_sign_extend}, 32'h1);

    // Reset asserted while holding a word
    applyStimulus(0, 1, 0, 0, 1, 1, 0);
    applyStimulus(1, 1, 0, 0, 0, 0, 0);
    checkOutput("hold_reset_valid", {31'h0, if_valid}, 32'h0);
    checkOutput("hold_reset_pc", imem_addr, 32'h0);
    applyStimulus(0, 0, 0, 0, 1, 1, 0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      applyStimulus(($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 30),
                    ($urandom_range(0, 99) < 10), $urandom,
                    ($urandom_range(0, 99) < 55), 0, rand_instr());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
